alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands in a DEPTH-entry FIFO, issues them one at a time to an external combinational ALU
// and holds each registered result (with divide-by-zero flag) until downstream accepts it.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Cmd_Valid,
  output logic       Cmd_Ready,
  input  logic [3:0] Cmd_Op,
  input  logic [7:0] Cmd_In1,
  input  logic [7:0] Cmd_In2,
  output logic [3:0] Alu_Op,
  output logic [7:0] Alu_In1,
  output logic [7:0] Alu_In2,
  input  logic [7:0] Alu_Out,
  output logic       Res_Valid,
  input  logic       Res_Ready,
  output logic [7:0] Res_Data,
  output logic [3:0] Res_Op,
  output logic       Res_Err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
  } cmd_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, capture, release_res, div_zero;

  assign Cmd_Ready = (count < CW'(DEPTH));
  assign push      = Cmd_Valid && Cmd_Ready;
  assign head      = mem[rd_ptr];
  assign div_zero  = (Alu_Op == 4'b0100) && (Alu_In2 == 8'h00);

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pop decisions use the registered count, so a command pushed this edge is issued next edge at the earliest.
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (Res_Ready) begin
          release_res = 1'b1;
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {Cmd_Op, Cmd_In1, Cmd_In2};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Alu_Op    <= '0;
      Alu_In1   <= '0;
      Alu_In2   <= '0;
      Res_Valid <= 1'b0;
      Res_Data  <= '0;
      Res_Op    <= '0;
      Res_Err   <= 1'b0;
    end else begin
      if (pop) begin
        Alu_Op  <= head.op;
        Alu_In1 <= head.in1;
        Alu_In2 <= head.in2;
      end
      if (capture) begin
        Res_Valid <= 1'b1;
        Res_Op    <= Alu_Op;
        Res_Data  <= div_zero ? 8'hFF : Alu_Out;
        Res_Err   <= div_zero;
      end else if (release_res) begin
        Res_Valid <= 1'b0;
      end
    end
  end

endmodule
